// File: rtl/dunit_pkg.sv
// Shared constants for the debug-unit IF controller: FSM state codes,
// UART command bytes and the instruction word that terminates a load.
package dunit_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_STEP  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
    localparam logic [7:0] CMD_CONT = 8'h43;  // 'C'
    localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'
    localparam logic [7:0] CMD_NEXT = 8'h4E;  // 'N'
    localparam logic [7:0] CMD_EXIT = 8'h45;  // 'E'
    localparam logic [7:0] CMD_RST  = 8'h52;  // 'R'

    localparam logic [31:0] HALT_INSTR_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/dunit_word_packer.sv
// Packs four consecutive RX bytes (first byte = MSB) into one instruction word.
// word_ready flags the byte that completes a word; word_next is that word.
module dunit_word_packer #(
    parameter int NB_BYTE = 8,
    parameter int NB_REG  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               byte_valid,
    input  logic [NB_BYTE-1:0] byte_in,
    output logic [NB_REG-1:0]  word_next,
    output logic               word_ready
);

    logic [NB_REG-NB_BYTE-1:0] shift_r;
    logic [1:0]                cnt_r;

    assign word_next  = {shift_r, byte_in};
    assign word_ready = byte_valid & (cnt_r == 2'd3);

    // Shift register and byte counter; clr abandons any partial word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r <= '0;
            cnt_r   <= 2'd0;
        end else if (clr) begin
            shift_r <= '0;
            cnt_r   <= 2'd0;
        end else if (byte_valid) begin
            shift_r <= word_next[NB_REG-NB_BYTE-1:0];
            cnt_r   <= cnt_r + 2'd1;
        end else begin
            shift_r <= shift_r;
            cnt_r   <= cnt_r;
        end
    end

endmodule

// File: rtl/dunit_if_ctrl.sv
// Debug-unit controller: loads instruction memory from UART bytes and gates the
// pipeline clock enable. Optional load timeout under `DUNIT_LOAD_TIMEOUT_EN.
module dunit_if_ctrl
    import dunit_pkg::*;
#(
    parameter int              NB_REG         = 32,
    parameter int              NB_ADDR        = 9,
    parameter int              NB_BYTE        = 8,
    parameter logic [NB_REG-1:0] HALT_INSTR   = HALT_INSTR_DEFAULT,
    parameter int              TIMEOUT_CYCLES = 1_000_000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic               i_rx_valid,
    input  logic               i_halt,
    output logic               o_dunit_clk_en,
    output logic               o_dunit_w_en,
    output logic [NB_ADDR-1:0] o_dunit_addr,
    output logic [NB_REG-1:0]  o_dunit_data,
    output logic [2:0]         o_state,
    output logic               o_error
);

    localparam logic [NB_ADDR-1:0] ADDR_LAST = {{(NB_ADDR-2){1'b1}}, 2'b00};
    localparam logic [NB_ADDR-1:0] ADDR_STEP = {{(NB_ADDR-3){1'b0}}, 3'b100};

    logic [2:0]         state_r, state_next_s;
    logic [NB_ADDR-1:0] addr_r, addr_next_s, out_addr_r;
    logic [NB_REG-1:0]  data_r;
    logic               w_en_r, clk_en_r, clk_en_next_s;
    logic               err_r, err_next_s;
    logic               pend_valid_r;
    logic [NB_BYTE-1:0] pend_byte_r;
    logic               byte_valid_s, pack_valid_s, pack_clr_s, word_ready_s, timeout_s;
    logic [NB_BYTE-1:0] byte_s;
    logic [NB_REG-1:0]  word_next_s;

    // A byte held over from the WRITE cycle takes priority on the following cycle.
    assign byte_valid_s = (state_r != ST_WRITE) & (pend_valid_r | i_rx_valid);
    assign byte_s       = pend_valid_r ? pend_byte_r : i_rx_data;
    assign pack_valid_s = byte_valid_s & (state_r == ST_LOAD);

    dunit_word_packer #(
        .NB_BYTE (NB_BYTE),
        .NB_REG  (NB_REG)
    ) u_packer (
        .clk        (i_clk),
        .rst_n      (i_reset),
        .clr        (pack_clr_s),
        .byte_valid (pack_valid_s),
        .byte_in    (byte_s),
        .word_next  (word_next_s),
        .word_ready (word_ready_s)
    );

`ifdef DUNIT_LOAD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_r;

    // Inactivity counter: runs only in LOAD and restarts on every accepted byte.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            to_cnt_r <= '0;
        end else if ((state_r != ST_LOAD) || pack_valid_s) begin
            to_cnt_r <= '0;
        end else begin
            to_cnt_r <= to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
        end
    end

    assign timeout_s = (state_r == ST_LOAD) & ~pack_valid_s &
                       (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));
`else
    // Without the counter a load can only time out for a degenerate zero limit.
    assign timeout_s = (TIMEOUT_CYCLES == 0) & (state_r == ST_LOAD) & ~pack_valid_s;
`endif

    // Next-state, address, error and clock-enable decisions.
    always_comb begin
        state_next_s  = state_r;
        addr_next_s   = addr_r;
        err_next_s    = err_r;
        clk_en_next_s = 1'b0;
        pack_clr_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (byte_valid_s) begin
                    case (byte_s)
                        CMD_LOAD: begin
                            state_next_s = ST_LOAD;
                            addr_next_s  = '0;
                            err_next_s   = 1'b0;
                            pack_clr_s   = 1'b1;
                        end
                        CMD_CONT: begin
                            state_next_s  = ST_RUN;
                            clk_en_next_s = 1'b1;
                        end
                        CMD_STEP: state_next_s = ST_STEP;
                        default:  state_next_s = ST_IDLE;
                    endcase
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (timeout_s) begin
                    state_next_s = ST_IDLE;
                    err_next_s   = 1'b1;
                    pack_clr_s   = 1'b1;
                end else if (word_ready_s) begin
                    state_next_s = ST_WRITE;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_WRITE: begin
                if (data_r == HALT_INSTR) begin
                    state_next_s = ST_IDLE;
                end else if (addr_r == ADDR_LAST) begin
                    state_next_s = ST_IDLE;
                    err_next_s   = 1'b1;
                end else begin
                    state_next_s = ST_LOAD;
                    addr_next_s  = addr_r + ADDR_STEP;
                end
            end
            ST_RUN: begin
                if (i_halt) begin
                    state_next_s = ST_DONE;
                end else begin
                    clk_en_next_s = 1'b1;
                end
            end
            ST_STEP: begin
                // A retiring HALT outranks a simultaneous 'N'.
                if (i_halt) begin
                    state_next_s = ST_DONE;
                end else if (byte_valid_s && (byte_s == CMD_NEXT)) begin
                    clk_en_next_s = 1'b1;
                end else if (byte_valid_s && (byte_s == CMD_EXIT)) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_STEP;
                end
            end
            ST_DONE: begin
                if (byte_valid_s && (byte_s == CMD_RST)) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Hold a byte that lands during the single WRITE cycle.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            pend_valid_r <= 1'b0;
            pend_byte_r  <= '0;
        end else if (state_r == ST_WRITE) begin
            pend_valid_r <= i_rx_valid;
            pend_byte_r  <= i_rx_data;
        end else begin
            pend_valid_r <= 1'b0;
            pend_byte_r  <= pend_byte_r;
        end
    end

    // State, address and registered output updates.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_r    <= ST_IDLE;
            addr_r     <= '0;
            out_addr_r <= '0;
            data_r     <= '0;
            w_en_r     <= 1'b0;
            clk_en_r   <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            addr_r   <= addr_next_s;
            err_r    <= err_next_s;
            clk_en_r <= clk_en_next_s;
            w_en_r   <= (state_next_s == ST_WRITE);
            if (state_next_s == ST_WRITE) begin
                out_addr_r <= addr_r;
            end else begin
                out_addr_r <= out_addr_r;
            end
            if (word_ready_s) begin
                data_r <= word_next_s;
            end else begin
                data_r <= data_r;
            end
        end
    end

    assign o_dunit_clk_en = clk_en_r;
    assign o_dunit_w_en   = w_en_r;
    assign o_dunit_addr   = out_addr_r;
    assign o_dunit_data   = data_r;
    assign o_state        = state_r;
    assign o_error        = err_r;

endmodule

// File: tb/tb_dunit_if_ctrl.sv
// Scoreboard bench for dunit_if_ctrl: expected instruction-memory writes are
// queued as bytes are sent and checked when w_en appears.
module tb_dunit_if_ctrl;

`ifdef DUNIT_LOAD_TIMEOUT_EN
    localparam int TB_TIMEOUT = 100;
`else
    localparam int TB_TIMEOUT = 1_000_000;
`endif

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        halt;
    logic        clk_en;
    logic        w_en;
    logic [8:0]  addr;
    logic [31:0] data;
    logic [2:0]  state;
    logic        error;

    typedef struct {
        logic [8:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_cmp = 0;
    int  n_err = 0;
    int  clk_en_cnt = 0;

    dunit_if_ctrl #(
        .NB_REG         (32),
        .NB_ADDR        (9),
        .NB_BYTE        (8),
        .HALT_INSTR     (32'hFFFF_FFFF),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .i_clk          (clk),
        .i_reset        (rst_n),
        .i_rx_data      (rx_data),
        .i_rx_valid     (rx_valid),
        .i_halt         (halt),
        .o_dunit_clk_en (clk_en),
        .o_dunit_w_en   (w_en),
        .o_dunit_addr   (addr),
        .o_dunit_data   (data),
        .o_state        (state),
        .o_error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Monitor on the falling edge: score writes, enforce w_en/clk_en exclusivity.
    always @(negedge clk) begin
        if (w_en) begin
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", {31'd0, w_en}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", {23'd0, addr}, {23'd0, mon_e.addr});
                chk("wr_data", data, mon_e.data);
            end
        end
        if (w_en || clk_en) chk("wen_clken_excl", {31'd0, w_en & clk_en}, 32'd0);
        if (clk_en) clk_en_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int idle);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        repeat (idle) tick();
    endtask

    task automatic send_word(input logic [31:0] w, input int idle);
        send_byte(w[31:24], idle);
        send_byte(w[23:16], idle);
        send_byte(w[15:8],  idle);
        send_byte(w[7:0],   idle);
    endtask

    task automatic push_wr(input logic [8:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    initial begin
        logic [31:0] w;
        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        halt     = 1'b0;
        repeat (3) tick();
        chk("rst_state",  {29'd0, state}, 32'd0);
        chk("rst_clk_en", {31'd0, clk_en}, 32'd0);
        chk("rst_w_en",   {31'd0, w_en}, 32'd0);
        chk("rst_addr",   {23'd0, addr}, 32'd0);
        chk("rst_data",   data, 32'd0);
        chk("rst_error",  {31'd0, error}, 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Load: first word back-to-back so the next byte lands in the WRITE cycle.
        push_wr(9'd0, 32'h2001_0005);
        push_wr(9'd4, 32'hFFFF_FFFF);
        send_byte(8'h4C, 1);
        send_word(32'h2001_0005, 0);
        send_byte(8'hFF, 1);
        send_byte(8'hFF, 1);
        send_byte(8'hFF, 1);
        send_byte(8'hFF, 3);
        chk("load_state", {29'd0, state}, 32'd0);
        chk("load_error", {31'd0, error}, 32'd0);
        chk("load_sb",    exp_q.size(), 32'd0);

        // Continuous run: halt during the 50th enabled cycle.
        clk_en_cnt = 0;
        send_byte(8'h43, 0);
        repeat (49) tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        repeat (5) tick();
        chk("run_clk_en_cycles", clk_en_cnt, 32'd50);
        chk("run_done_state",    {29'd0, state}, 32'd5);
        send_byte(8'h11, 2);
        chk("done_ignore",       {29'd0, state}, 32'd5);
        send_byte(8'h52, 2);
        chk("done_r_idle",       {29'd0, state}, 32'd0);

        // Single-step: two 'N' pulses then exit.
        clk_en_cnt = 0;
        send_byte(8'h53, 2);
        chk("step_state", {29'd0, state}, 32'd4);
        send_byte(8'h4E, 3);
        send_byte(8'h4E, 3);
        send_byte(8'h45, 3);
        chk("step_pulses",    clk_en_cnt, 32'd2);
        chk("step_exit_idle", {29'd0, state}, 32'd0);

        // 'N' and halt in the same cycle: halt wins.
        clk_en_cnt = 0;
        send_byte(8'h53, 2);
        halt = 1'b1;
        send_byte(8'h4E, 0);
        halt = 1'b0;
        repeat (3) tick();
        chk("step_halt_nopulse", clk_en_cnt, 32'd0);
        chk("step_halt_done",    {29'd0, state}, 32'd5);
        send_byte(8'h52, 2);

        // Fill all 128 words: error after address 508, no wrap.
        send_byte(8'h4C, 1);
        for (int i = 0; i < 128; i++) begin
            w = {8'hA5, 8'(i), 16'h3C00};
            push_wr(9'(i * 4), w);
            send_word(w, 1);
        end
        repeat (3) tick();
        chk("ovf_error", {31'd0, error}, 32'd1);
        chk("ovf_state", {29'd0, state}, 32'd0);
        chk("ovf_addr",  {23'd0, addr}, 32'd508);
        send_word(32'h1111_1111, 1);
        chk("ovf_ignore_state", {29'd0, state}, 32'd0);

        // Asynchronous reset in the middle of a word.
        send_byte(8'h4C, 1);
        chk("l_clears_error", {31'd0, error}, 32'd0);
        send_byte(8'h12, 1);
        send_byte(8'h34, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", {29'd0, state}, 32'd0);
        chk("arst_addr",  {23'd0, addr}, 32'd0);
        chk("arst_data",  data, 32'd0);
        chk("arst_w_en",  {31'd0, w_en}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        push_wr(9'd0, 32'hDEAD_BEEF);
        push_wr(9'd4, 32'hFFFF_FFFF);
        send_byte(8'h4C, 1);
        send_word(32'hDEAD_BEEF, 1);
        send_word(32'hFFFF_FFFF, 1);
        repeat (3) tick();
        chk("reload_state", {29'd0, state}, 32'd0);

`ifdef DUNIT_LOAD_TIMEOUT_EN
        // Three bytes then silence: timeout discards the word.
        send_byte(8'h4C, 1);
        send_byte(8'h01, 1);
        send_byte(8'h02, 1);
        send_byte(8'h03, 105);
        chk("to_error", {31'd0, error}, 32'd1);
        chk("to_state", {29'd0, state}, 32'd0);
`endif

        repeat (5) tick();
        chk("sb_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dunit_if_ctrl.md
Name: dunit_if_ctrl

Overview:
- Debug-unit controller sequencing the IF-stage instruction memory and the pipeline clock enable.
- Consumes command/data bytes from the UART RX, packs them into 32-bit words and writes them into instruction memory.
- Gates pipeline execution in continuous-run or single-step mode until a HALT retires.
- Sits between the UART RX and the IF stage's dunit_clk_en / dunit_w_en / dunit_addr / dunit_data inputs.

Parameters:
- NB_REG, 32, instruction/data word width.
- NB_ADDR, 9, instruction memory byte-address width (512 bytes).
- NB_BYTE, 8, RX byte width.
- HALT_INSTR, 32'hFFFF_FFFF, encoding that terminates a load.
- TIMEOUT_CYCLES, 1_000_000, load inactivity limit (used only with the optional feature).

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_rx_data  in  NB_BYTE  received byte.
- i_rx_valid  in  1  one-cycle strobe, i_rx_data valid.
- i_halt  in  1  one-cycle pulse, HALT retired in WB.
- o_dunit_clk_en  out  1  pipeline/PC enable.
- o_dunit_w_en  out  1  instruction memory write strobe.
- o_dunit_addr  out  NB_ADDR  instruction memory byte address.
- o_dunit_data  out  NB_REG  instruction word to write.
- o_state  out  3  current FSM state, for LEDs/debug.
- o_error  out  1  sticky: address overflow or load timeout.

Behaviour:
- Reset (i_reset low, async): state IDLE; all outputs 0; byte counter 0; address 0; o_error 0.
- Command bytes, accepted only in IDLE; any other byte in IDLE is ignored:
  - 'L' (8'h4C): address := 0, byte counter := 0, clear o_error, go to LOAD.
  - 'C' (8'h43): go to RUN.
  - 'S' (8'h53): go to STEP.
- LOAD:
  - Each i_rx_valid shifts the byte into the word, first byte = MSB.
  - After the 4th byte: next cycle enter WRITE with o_dunit_data = packed word and o_dunit_addr = current address.
- WRITE (exactly 1 cycle):
  - o_dunit_w_en = 1; a byte arriving during WRITE is held and consumed in LOAD on the next cycle (no loss).
  - If the word == HALT_INSTR: go to IDLE, address unchanged.
  - Else if address == 2^NB_ADDR-4: set o_error, go to IDLE (no wrap).
  - Else: address += 4, go to LOAD.
- RUN:
  - o_dunit_clk_en = 1 every cycle.
  - On i_halt: clk_en drops the following cycle, go to DONE.
  - RX bytes are ignored.
- STEP:
  - o_dunit_clk_en = 0 except one-cycle pulse per 'N' (8'h4E).
  - 'E' (8'h45) returns to IDLE.
  - i_halt → DONE.
  - i_halt and 'N' in the same cycle: halt wins, no pulse.
- DONE:
  - clk_en = 0.
  - Only 'R' (8'h52) → IDLE; all other bytes ignored.
- o_dunit_w_en and o_dunit_clk_en are never asserted in the same cycle.
- o_dunit_addr holds its last value outside WRITE.
- Reset mid-load abandons the partial word; no write occurs.
- o_state encoding: IDLE=0, LOAD=1, WRITE=2, RUN=3, STEP=4, DONE=5.

Optional Feature:
- DUNIT_LOAD_TIMEOUT_EN defined:
  - Cycle counter runs in LOAD and restarts on each i_rx_valid.
  - Reaching TIMEOUT_CYCLES sets o_error, discards the partial word and returns to IDLE.
- Undefined: LOAD waits indefinitely; no counter is synthesized.

Decomposition:
- Package dunit_pkg:
  - state enum/localparams.
  - command byte constants (CMD_LOAD, CMD_CONT, CMD_STEP, CMD_NEXT, CMD_EXIT, CMD_RST).
  - HALT_INSTR default.
- One sub-module, dunit_word_packer: shift register plus 2-bit byte counter, producing word and word_ready; reset/clear input.
- FSM, address counter and timeout counter stay in dunit_if_ctrl.

Test Plan:
- 'L', then bytes 20 01 00 05 and FF FF FF FF → w_en pulses with addr 0 / data 0x20010005, then addr 4 / data 0xFFFFFFFF; state returns to IDLE; o_error 0.
- 'C', then i_halt pulse 50 cycles later → clk_en high for exactly 50 cycles, then DONE; 'R' → IDLE.
- 'S', 'N', 'N', 'E' → exactly two single-cycle clk_en pulses, then IDLE; 'N' and i_halt same cycle → no pulse, DONE.
- Load 128 non-HALT words → writes to addr 0..508, o_error = 1 after addr 508, IDLE, no write to addr 0 again.
- Reset asserted after 2 bytes of a word → outputs 0 immediately (async); a fresh load writes the next complete word at addr 0.
- With DUNIT_LOAD_TIMEOUT_EN, TIMEOUT_CYCLES = 100: 'L', 3 bytes, idle 100 cycles → o_error = 1, IDLE, no w_en.
